// File: rtl/fetch_queue_unit_if.sv
// Fetch-queue port bundle: instruction-memory side, decode-side valid/ready,
// redirect request and status. The unit is the master; its environment is the slave.
interface fetch_queue_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] imem_addr;
    logic              imem_en;
    logic [31:0]       imem_instr;

    logic              valid;
    logic              ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;

    logic              redirect;
    logic [1:0]        redirect_mode;
    logic [ADDR_W-1:0] redirect_base;
    logic [25:0]       redirect_imm;
    logic [ADDR_W-1:0] redirect_reg;

    logic              misalign;
    logic [CW-1:0]     count;

    modport master (
        output imem_addr, imem_en,
        input  imem_instr,
        output valid, instr, pc, pc_plus4,
        input  ready,
        input  redirect, redirect_mode, redirect_base, redirect_imm, redirect_reg,
        output misalign, count
    );

    modport slave (
        input  imem_addr, imem_en,
        output imem_instr,
        input  valid, instr, pc, pc_plus4,
        output ready,
        output redirect, redirect_mode, redirect_base, redirect_imm, redirect_reg,
        input  misalign, count
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, reads a combinational imem and
// buffers {pc, instr} pairs in a circular queue; branch/jump/jr redirects flush it.
module fetch_queue_unit #(
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_queue_unit_if.master  fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              misalign_reg;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];

    logic [ADDR_W-1:0] base_plus4;
    logic [ADDR_W-1:0] sext_imm;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] raw_target;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic [CW-1:0]     count_next;

    // Redirect target arithmetic, all modulo 2^ADDR_W.
    assign base_plus4    = fq.redirect_base + FOUR;
    assign sext_imm      = {{(ADDR_W-16){fq.redirect_imm[15]}}, fq.redirect_imm[15:0]};
    assign branch_target = base_plus4 + (sext_imm << 2);
    assign jump_target   = {base_plus4[ADDR_W-1:28], fq.redirect_imm, 2'b00};

    always_comb begin
        raw_target = fq.redirect_reg;
        case (fq.redirect_mode)
            2'b00:   raw_target = branch_target;
            2'b01:   raw_target = jump_target;
            default: raw_target = fq.redirect_reg;
        endcase
    end

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == CW'(DEPTH));
    assign pop        = !empty && fq.ready;
    // A pop frees the head slot in the same edge, so a full queue can still accept.
    assign push       = !fq.redirect && (!full || pop);
    assign count_next = count_reg + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            misalign_reg <= 1'b0;
        end else if (fq.redirect) begin
            // Flush dominates any same-cycle pop; the wrong-path word is dropped.
            fetch_pc_reg <= {raw_target[ADDR_W-1:2], 2'b00};
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            if (raw_target[1:0] != 2'b00) begin
                misalign_reg <= 1'b1;
            end
        end else begin
            if (push) begin
                fetch_pc_reg <= fetch_pc_reg + FOUR;
                wr_ptr_reg   <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Queue storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
            instr_mem[wr_ptr_reg] <= fq.imem_instr;
        end
    end

    assign fq.imem_addr = fetch_pc_reg;
    assign fq.imem_en   = push;
    assign fq.valid     = !empty;
    assign fq.instr     = empty ? 32'd0 : instr_mem[rd_ptr_reg];
    assign fq.pc        = empty ? '0 : pc_mem[rd_ptr_reg];
    assign fq.pc_plus4  = empty ? '0 : pc_mem[rd_ptr_reg] + FOUR;
    assign fq.misalign  = misalign_reg;
    assign fq.count     = count_reg;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus a randomized
// run against a queue-based reference model of the fetch front end.
module tb_fetch_queue_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] mfpc;
    logic        mmis;

    fetch_queue_unit_if #(.ADDR_W(32), .DEPTH(DEPTH)) fq ();
    fetch_queue_unit_if #(.ADDR_W(32), .DEPTH(DEPTH)) fq_w ();

    fetch_queue_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .fq(fq)
    );
    fetch_queue_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .fq(fq_w)
    );

    assign fq.imem_instr   = fq.imem_addr >> 2;
    assign fq_w.imem_instr = fq_w.imem_addr >> 2;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        mfpc = 32'h0;
        mmis = 1'b0;
    endtask

    function automatic logic [31:0] calc_target(logic [1:0] mode, logic [31:0] base,
                                                logic [25:0] imm, logic [31:0] r);
        int off;
        off = $signed(imm[15:0]);
        case (mode)
            2'b00:   return base + 32'd4 + 32'(off * 4);
            2'b01:   return ((base + 32'd4) & 32'hF000_0000) | (32'(imm) << 2);
            default: return r;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] t;
        if (fq.redirect) begin
            t = calc_target(fq.redirect_mode, fq.redirect_base, fq.redirect_imm, fq.redirect_reg);
            if (t[1:0] != 2'b00) mmis = 1'b1;
            mfpc = t & 32'hFFFF_FFFC;
            mq.delete();
        end else begin
            if (mq.size() > 0 && fq.ready) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back(mfpc);
                mfpc = mfpc + 32'd4;
            end
        end
    endtask

    task automatic set_redirect(logic [1:0] mode, logic [31:0] base, logic [25:0] imm, logic [31:0] r);
        fq.redirect      = 1'b1;
        fq.redirect_mode = mode;
        fq.redirect_base = base;
        fq.redirect_imm  = imm;
        fq.redirect_reg  = r;
        $display("redirect mode=%0d base=%h imm=%h reg=%h", mode, base, imm, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fq.redirect = 1'b0;
        fq.ready = 1'b0;
        fq_w.ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (fq.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", fq.valid); end
        checks++; if (fq.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", fq.imem_addr); end
        checks++; if (fq.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fq.count); end
        checks++; if (fq.misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", fq.misalign); end
        checks++; if (fq.instr !== 32'h0 || fq.pc !== 32'h0 || fq.pc_plus4 !== 32'h0) begin
            failures++; $display("FAIL reset_head instr=%h pc=%h pc4=%h exp=0", fq.instr, fq.pc, fq.pc_plus4); end
        checks++; if (fq_w.imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL reset_addr_wrap got=%h exp=fffffff8", fq_w.imem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (fq.imem_en !== 1'b1) begin failures++; $display("FAIL reset_en got=%b exp=1", fq.imem_en); end
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_fill();
        do_reset();
        repeat (DEPTH) tick();
        checks++; if (fq.count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", fq.count); end
        checks++; if (fq.imem_addr !== 32'h10) begin failures++; $display("FAIL fill_addr got=%h exp=10", fq.imem_addr); end
        checks++; if (fq.imem_en !== 1'b0) begin failures++; $display("FAIL fill_en got=%b exp=0", fq.imem_en); end
        checks++; if (fq.valid !== 1'b1 || fq.pc !== 32'h0 || fq.instr !== 32'h0) begin
            failures++; $display("FAIL fill_head valid=%b pc=%h instr=%h exp=1/0/0", fq.valid, fq.pc, fq.instr); end
        tick();
        checks++; if (fq.imem_addr !== 32'h10 || fq.count !== 3'd4) begin
            failures++; $display("FAIL fill_hold addr=%h count=%0d exp=10/4", fq.imem_addr, fq.count); end
        $display("test_fill done");
    endtask

    task automatic test_stream();
        do_reset();
        fq.ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (fq.pc !== 32'(i * 4) || fq.pc_plus4 !== 32'(i * 4 + 4) || fq.instr !== 32'(i)) begin
                failures++; $display("FAIL stream_head[%0d] pc=%h pc4=%h instr=%h exp=%h/%h/%h",
                                     i, fq.pc, fq.pc_plus4, fq.instr, i * 4, i * 4 + 4, i); end
            checks++; if (fq.count !== 3'd1 || fq.valid !== 1'b1) begin
                failures++; $display("FAIL stream_count[%0d] count=%0d valid=%b exp=1/1", i, fq.count, fq.valid); end
            $display("stream pc=%h instr=%h", fq.pc, fq.instr);
            tick();
        end
    endtask

    task automatic test_branch();
        do_reset();
        fq.ready = 1'b1;
        tick();
        tick();
        set_redirect(2'b00, 32'h8, 26'h000FFFF, 32'h0);
        tick();
        fq.redirect = 1'b0;
        checks++; if (fq.valid !== 1'b0 || fq.imem_addr !== 32'h8 || fq.count !== 3'd0) begin
            failures++; $display("FAIL branch_bubble valid=%b addr=%h count=%0d exp=0/8/0", fq.valid, fq.imem_addr, fq.count); end
        tick();
        checks++; if (fq.valid !== 1'b1 || fq.pc !== 32'h8 || fq.instr !== 32'h2) begin
            failures++; $display("FAIL branch_head valid=%b pc=%h instr=%h exp=1/8/2", fq.valid, fq.pc, fq.instr); end
        set_redirect(2'b00, 32'h8, 26'h0000003, 32'h0);
        tick();
        fq.redirect = 1'b0;
        checks++; if (fq.imem_addr !== 32'h18 || fq.valid !== 1'b0) begin
            failures++; $display("FAIL branch_fwd addr=%h valid=%b exp=18/0", fq.imem_addr, fq.valid); end
        tick();
        checks++; if (fq.pc !== 32'h18) begin failures++; $display("FAIL branch_fwd_head got=%h exp=18", fq.pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        fq_w.ready = 1'b1;
        tick();
        checks++; if (fq_w.pc !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_pc0 got=%h exp=fffffff8", fq_w.pc); end
        tick();
        checks++; if (fq_w.pc !== 32'hFFFF_FFFC || fq_w.pc_plus4 !== 32'h0) begin
            failures++; $display("FAIL wrap_pc1 pc=%h pc4=%h exp=fffffffc/0", fq_w.pc, fq_w.pc_plus4); end
        tick();
        checks++; if (fq_w.pc !== 32'h0) begin failures++; $display("FAIL wrap_pc2 got=%h exp=0", fq_w.pc); end
        fq_w.ready = 1'b0;
        $display("test_wrap done");
    endtask

    task automatic test_full_flush();
        do_reset();
        repeat (DEPTH) tick();
        fq.ready = 1'b1;
        set_redirect(2'b10, 32'h0, 26'h0, 32'h40);
        #1;
        checks++; if (fq.imem_en !== 1'b0) begin failures++; $display("FAIL flush_en got=%b exp=0", fq.imem_en); end
        tick();
        fq.redirect = 1'b0;
        checks++; if (fq.count !== 3'd0 || fq.valid !== 1'b0 || fq.imem_addr !== 32'h40) begin
            failures++; $display("FAIL flush_state count=%0d valid=%b addr=%h exp=0/0/40", fq.count, fq.valid, fq.imem_addr); end
    endtask

    task automatic test_jump_jr();
        do_reset();
        fq.ready = 1'b1;
        tick();
        set_redirect(2'b01, 32'h1000_0000, 26'h40, 32'h0);
        tick();
        fq.redirect = 1'b0;
        checks++; if (fq.imem_addr !== 32'h1000_0100) begin failures++; $display("FAIL jump_addr got=%h exp=10000100", fq.imem_addr); end
        tick();
        checks++; if (fq.pc !== 32'h1000_0100) begin failures++; $display("FAIL jump_head got=%h exp=10000100", fq.pc); end
        set_redirect(2'b10, 32'h0, 26'h0, 32'h203);
        tick();
        fq.redirect = 1'b0;
        checks++; if (fq.imem_addr !== 32'h200 || fq.misalign !== 1'b1) begin
            failures++; $display("FAIL jr_misalign addr=%h mis=%b exp=200/1", fq.imem_addr, fq.misalign); end
        tick();
        set_redirect(2'b00, 32'h200, 26'h0, 32'h0);
        tick();
        set_redirect(2'b11, 32'h0, 26'h0, 32'h300);
        tick();
        fq.redirect = 1'b0;
        checks++; if (fq.imem_addr !== 32'h300 || fq.misalign !== 1'b1) begin
            failures++; $display("FAIL jr_sticky addr=%h mis=%b exp=300/1", fq.imem_addr, fq.misalign); end
    endtask

    task automatic test_async_reset();
        fq.ready = 1'b1;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (fq.valid !== 1'b0 || fq.imem_addr !== 32'h0 || fq.count !== 3'd0) begin
            failures++; $display("FAIL async_reset valid=%b addr=%h count=%0d exp=0/0/0", fq.valid, fq.imem_addr, fq.count); end
        checks++; if (fq.misalign !== 1'b0) begin failures++; $display("FAIL async_misalign got=%b exp=0", fq.misalign); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] epc4;
        logic        een;
        int          nfail;
        do_reset();
        nfail = failures;
        for (int i = 0; i < 400; i++) begin
            fq.ready         = ($urandom_range(0, 99) < 65);
            fq.redirect      = ($urandom_range(0, 99) < 12);
            fq.redirect_mode = 2'($urandom_range(0, 3));
            fq.redirect_base = 32'($urandom_range(0, 32'hFFFF)) << 2;
            fq.redirect_imm  = 26'($urandom);
            fq.redirect_reg  = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            #1;
            ev     = (mq.size() != 0);
            epc    = ev ? mq[0] : 32'h0;
            einstr = ev ? (mq[0] >> 2) : 32'h0;
            epc4   = ev ? mq[0] + 32'd4 : 32'h0;
            een    = !fq.redirect && (mq.size() < DEPTH || (ev && fq.ready));
            checks++; if (fq.valid !== ev || fq.pc !== epc || fq.instr !== einstr || fq.pc_plus4 !== epc4) begin
                failures++; $display("FAIL rand_head[%0d] valid=%b pc=%h instr=%h pc4=%h exp=%b/%h/%h/%h",
                                     i, fq.valid, fq.pc, fq.instr, fq.pc_plus4, ev, epc, einstr, epc4); end
            checks++; if (fq.count !== 3'(mq.size()) || fq.imem_addr !== mfpc) begin
                failures++; $display("FAIL rand_state[%0d] count=%0d addr=%h exp=%0d/%h", i, fq.count, fq.imem_addr, mq.size(), mfpc); end
            checks++; if (fq.imem_en !== een || fq.misalign !== mmis) begin
                failures++; $display("FAIL rand_ctrl[%0d] en=%b mis=%b exp=%b/%b", i, fq.imem_en, fq.misalign, een, mmis); end
            @(posedge clk);
            model_step();
            #1;
        end
        fq.redirect = 1'b0;
        $display("test_random done errors=%0d", failures - nfail);
    endtask

    initial begin
        fq.ready = 1'b0;
        fq.redirect = 1'b0;
        fq.redirect_mode = 2'b00;
        fq.redirect_base = 32'h0;
        fq.redirect_imm = 26'h0;
        fq.redirect_reg = 32'h0;
        fq_w.ready = 1'b0;
        fq_w.redirect = 1'b0;
        fq_w.redirect_mode = 2'b00;
        fq_w.redirect_base = 32'h0;
        fq_w.redirect_imm = 26'h0;
        fq_w.redirect_reg = 32'h0;
        model_reset();
        test_reset();
        test_fill();
        test_stream();
        test_branch();
        test_wrap();
        test_full_flush();
        test_jump_jr();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end for the MIPS CPU family. It owns the program counter, drives the combinational instruction memory, and buffers fetched instructions with their PCs in a DEPTH-entry queue. It exposes a valid/ready interface to decode and resolves all next-PC redirects internally: branch, jump and jump-register. This decouples fetch from a stalling back end, so the single-cycle datapath can grow into a multi-cycle or pipelined core.

## Interface
- ADDR_W, 32, PC/address width; legal range 29..32.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, fetch address after reset; bits [1:0] must be 00.

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- imem_addr_o  out  ADDR_W  current fetch address (registered fetch PC)
- imem_en_o  out  1  high in cycles where the fetched word is written into the queue
- imem_instr_i  in  32  instruction at imem_addr_o, valid in the same cycle (combinational memory)
- valid_o  out  1  queue head valid
- ready_i  in  1  consumer accepts head
- instr_o  out  32  head instruction
- pc_o  out  ADDR_W  head PC
- pc_plus4_o  out  ADDR_W  head PC + 4, modulo 2^ADDR_W
- redirect_i  in  1  redirect request
- redirect_mode_i  in  2  00 branch, 01 jump, 10 jr, 11 treated as jr
- redirect_base_i  in  ADDR_W  PC of the redirecting instruction
- redirect_imm_i  in  26  branch uses [15:0]; jump uses [25:0]
- redirect_reg_i  in  ADDR_W  jr target (rs value)
- misalign_o  out  1  sticky: a redirect target had nonzero bits [1:0]
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Queue: circular buffer with read/write pointers and an occupancy count. Each entry holds {pc, instr}.
- Write condition (imem_en_o): !redirect_i && (count<DEPTH || (valid_o && ready_i)).
  - On write, store {imem_addr_o, imem_instr_i} at the write pointer.
  - Fetch PC advances by 4, wrapping modulo 2^ADDR_W.
- Dequeue: valid_o && ready_i pops the head. Full queue with simultaneous pop and write: count unchanged.
- Empty: valid_o=0; instr_o, pc_o and pc_plus4_o are driven 0.
- Redirect target, computed in the unit:
  - Branch: base + 4 + (sext(imm[15:0]) << 2).
  - Jump: {(base+4)[ADDR_W-1:28], imm[25:0], 2'b00}.
  - jr/11: reg.
- Alignment: the target's bits [1:0] are forced to 00. If the raw bits were nonzero, misalign_o is set. It clears only on reset.
- On a redirect edge:
  - The queue is flushed (count←0, pointers←0) and fetch PC←target.
  - The wrong-path word at the old imem_addr_o is discarded.
  - A pop in the same cycle is still counted as consumed, but the flush dominates.
- Consecutive redirects: the last one wins. Each re-flushes.
- Reset (any time, including mid-flush or full): fetch PC←RESET_PC, queue empty, misalign_o=0. Outputs change immediately, without waiting for a clock edge.

## Timing
- Reset values: imem_addr_o=RESET_PC, imem_en_o=1 once rst_i is released, valid_o=0, instr_o=0, pc_o=0, pc_plus4_o=0, count_o=0, misalign_o=0.
- Startup: first edge after reset release writes RESET_PC; valid_o=1 from the following cycle.
- Redirect latency:
  - Edge E samples redirect_i.
  - Cycle after E: imem_addr_o=target, valid_o=0.
  - Edge E+1 writes the target.
  - valid_o=1 after E+1, with pc_o=target.
  - Cost: exactly one bubble cycle.
- Steady state with ready_i=1: one instruction per cycle, no bubbles.
- Backpressure with ready_i=0: fills to DEPTH in DEPTH edges, then imem_en_o=0 and imem_addr_o holds.

## Test plan
- Fill: DEPTH=4, RESET_PC=0, ready_i=0, imem returns addr>>2 → after 4 edges: count_o=4, imem_addr_o=0x10, imem_en_o=0, pc_o=0, instr_o=0.
- Stream: ready_i=1 from reset → pc_o sequence 0,4,8,C on consecutive cycles; count_o stays 1; pc_plus4_o=pc_o+4.
- Branch: redirect mode 00, base 0x8, imm 0xFFFF → flush; next cycle valid_o=0, imem_addr_o=0x8; following cycle pc_o=0x8. Imm 0x0003 → target 0x18.
- Jump and jr:
  - Mode 01, base 0x1000_0000, imm 0x40 → target 0x1000_0100.
  - Mode 10, reg 0x203 → target 0x200, misalign_o=1 and it stays 1 after later redirects.
- Wrap: RESET_PC=0xFFFF_FFF8, ready_i=1 → pc_o 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Boundary/reset: full queue with ready_i=1 and redirect_i=1 in the same cycle → count_o=0 next cycle. Assert rst_i=0 mid-stream between edges → valid_o=0 and imem_addr_o=RESET_PC immediately.
